alu_system: RTL and testbench
=============================

// Module: alu_system
// PURPOSE
//  Datapath top for the teaching CPU: 4-entry general register file (R1-R4), address register file (PC, AR, SP),
//  16-bit instruction register, 8-bit ALU with flags, 256x8 memory and three source muxes.
//  All control is raw select lines driven by the testbench or a later control unit.
//  No sequencer lives here.
// PARAMETERS
//  DATA_W     8    datapath / register / memory word width
//  MEM_DEPTH  256  memory words; addressed by ARF OutD
// PORTS
//  Clock        in   1  single clock; all state updates on rising edge
//  Reset        in   1  asynchronous, active-high; clears every register and the flags
//  RF_OutASel   in   2  AOut source: 00 R1, 01 R2, 10 R3, 11 R4
//  RF_OutBSel   in   2  BOut source, same encoding
//  RF_FunSel    in   2  register op (see FUNSEL)
//  RF_RegSel    in   4  active-low enables: bit3 R1, bit2 R2, bit1 R3, bit0 R4
//  ALU_FunSel   in   4  ALU operation (see ALU)
//  ARF_OutCSel  in   2  COut source: 00 PC, 01 PC, 10 AR, 11 SP
//  ARF_OutDSel  in   2  Address source, same encoding
//  ARF_FunSel   in   2  register op
//  ARF_RegSel   in   3  active-low enables: bit2 PC, bit1 AR, bit0 SP
//  IR_LH        in   1  IR load half: 0 low byte, 1 high byte
//  IR_Enable    in   1  IR update enable (active-high)
//  IR_Funsel    in   2  IR op
//  Mem_WR       in   1  1 write, 0 read
//  Mem_CS       in   1  active-low chip select
//  MuxASel      in   2  RF input: 00 ALUOut, 01 MemoryOut, 10 IROut[7:0], 11 ARF_COut
//  MuxBSel      in   2  ARF input: same encoding as MuxA
//  MuxCSel      in   1  ALU A input: 0 AOut, 1 ARF_COut
//  AOut, BOut, ALUOut, ARF_COut, Address, MemoryOut, MuxAOut, MuxBOut, MuxCOut
//               out  8 each  observation taps
//  ALUOutFlag   out  4  {Z,C,N,O} registered flags
//  IROut        out  16 instruction register
// BEHAVIOUR
//  FUNSEL (all registers, applied at the clock edge only when enabled):
//   00 Q-1, 01 Q+1, 10 Q=I, 11 Q=0
//   Inc/dec wrap modulo 2^width. A disabled register holds its value.
//  RF and ARF:
//   Input is MuxAOut and MuxBOut respectively.
//   All selected registers perform the same op in the same cycle.
//   Reads are combinational.
//  IR:
//   Load (10) writes MuxA-independent memory data MemoryOut into the half chosen by IR_LH.
//   The other half holds.
//   Inc/dec/clear act on the full 16 bits.
//   IR_Enable=0 holds.
//  ALU:
//   Combinational ALUOut from A=MuxCOut, B=BOut.
//   Opcodes:
//    0 A          1 B          2 ~A         3 ~B
//    4 A+B        5 A-B        6 A-B (compare)
//    7 A&B        8 A|B        9 ~(A&B)     A A^B
//    B LSL A      C LSR A      D ASL A      E ASR A (sign kept)
//    F CSR A (rotate right; out[7]=A[0])
//  Flags:
//   Registered every rising edge, no enable.
//   Z = (ALUOut==0) and N = ALUOut[7] for every op.
//   C:
//    add: carry-out.
//    sub/compare: carry-out of A+~B+1, i.e. 1 = no borrow.
//    LSL/ASL: A[7].
//    LSR/ASR/CSR: A[0].
//    Otherwise C holds.
//   O:
//    add/sub/compare: signed overflow.
//    ASL: A[7]^A[6].
//    Otherwise O holds.
//  Memory:
//   Data in = ALUOut; address = Address.
//   Write is synchronous when Mem_CS=0 and Mem_WR=1.
//   Read is combinational when Mem_CS=0 and Mem_WR=0.
//   MemoryOut=0 when Mem_CS=1 or during a write.
//   Contents power up 0 and are not affected by Reset.
//  Reset:
//   Asserted at any time, immediately zeroes R1-R4, PC, AR, SP, IR and flags.
//   While Reset is high all register updates are blocked.
//  Same-cycle read and write of a register:
//   Readers see the old value; the new value is visible after the edge.
// STRUCTURE
//  Package alu_system_pkg:
//   FUNSEL constants (DEC/INC/LOAD/CLR)
//   ALU opcode enum
//   mux select constants
//  Sub-module nbit_reg #(N):
//   Clock, Reset, E, FunSel, I, Q.
//   Instantiated 4x in the RF, 3x in the ARF.
//   The IR wraps one 16-bit instance with half-load logic.
// TESTING
//  Reset=1 mid-run -> AOut, BOut, ARF_COut, IROut, ALUOutFlag all 0 before the next edge.
//  MuxASel=11 with PC cleared then incremented 3x; RF_RegSel=0111, RF_FunSel=10 -> R1=3; OutASel=00 shows 3.
//  R1=0x7F, R2=0x01, ALU_FunSel=4 -> ALUOut=0x80; next edge flags Z0 C0 N1 O1.
//  R1=R2=0x55, ALU_FunSel=6 -> ALUOut=0, Z=1, C=1; ALU_FunSel=F on 0x01 -> 0x80, C=1.
//  ALUOut=0xAB, AR=0x10, Mem_CS=0, WR=1 edge; then WR=0 -> MemoryOut=0xAB.
//   IR_Enable=1, LH=1, Funsel=10 -> IROut=0xAB00; Mem_CS=1 -> MemoryOut=0.
//  ARF_RegSel=111 with any FunSel over 4 edges -> PC/AR/SP unchanged; RF dec from 0 -> 0xFF.

Source files
------------

// File: rtl/alu_system_pkg.sv
// Shared constants and types for the teaching-CPU datapath: register op
// codes, ALU opcodes, source-mux encodings and the ARF read-port picker.
package alu_system_pkg;

    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 256;
    localparam int MSB       = DATA_W - 1;
    localparam int IR_W      = 2 * DATA_W;

    // Register operations shared by RF, ARF and IR
    localparam logic [1:0] FUN_DEC  = 2'b00;
    localparam logic [1:0] FUN_INC  = 2'b01;
    localparam logic [1:0] FUN_LOAD = 2'b10;
    localparam logic [1:0] FUN_CLR  = 2'b11;

    typedef enum logic [3:0] {
        ALU_PASS_A = 4'h0,
        ALU_PASS_B = 4'h1,
        ALU_NOT_A  = 4'h2,
        ALU_NOT_B  = 4'h3,
        ALU_ADD    = 4'h4,
        ALU_SUB    = 4'h5,
        ALU_CMP    = 4'h6,
        ALU_AND    = 4'h7,
        ALU_OR     = 4'h8,
        ALU_NAND   = 4'h9,
        ALU_XOR    = 4'hA,
        ALU_LSL    = 4'hB,
        ALU_LSR    = 4'hC,
        ALU_ASL    = 4'hD,
        ALU_ASR    = 4'hE,
        ALU_CSR    = 4'hF
    } aluOp_t;

    // MuxA / MuxB source encodings
    localparam logic [1:0] MUX_ALU  = 2'b00;
    localparam logic [1:0] MUX_MEM  = 2'b01;
    localparam logic [1:0] MUX_IR   = 2'b10;
    localparam logic [1:0] MUX_ARFC = 2'b11;

    // MuxC source encodings
    localparam logic MUXC_AOUT = 1'b0;
    localparam logic MUXC_ARFC = 1'b1;

    // ARF read-port encodings; both 00 and 01 read PC
    localparam logic [1:0] ARF_SEL_PC     = 2'b00;
    localparam logic [1:0] ARF_SEL_PC_ALT = 2'b01;
    localparam logic [1:0] ARF_SEL_AR     = 2'b10;
    localparam logic [1:0] ARF_SEL_SP     = 2'b11;

    // Read-port mux shared by the COut and Address ports of the ARF
    function automatic logic [DATA_W-1:0] arfPick(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] pc,
        input logic [DATA_W-1:0] ar,
        input logic [DATA_W-1:0] sp
    );
        logic [DATA_W-1:0] res;
        res = pc;
        case (sel)
            ARF_SEL_PC, ARF_SEL_PC_ALT: res = pc;
            ARF_SEL_AR:                 res = ar;
            ARF_SEL_SP:                 res = sp;
            default:                    res = pc;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_system_if.sv
// Control selects and observation taps of the datapath. The master side is
// the testbench or a future control unit; the datapath is the slave.
interface alu_system_if;
    import alu_system_pkg::*;

    logic [1:0]        RF_OutASel;
    logic [1:0]        RF_OutBSel;
    logic [1:0]        RF_FunSel;
    logic [3:0]        RF_RegSel;
    logic [3:0]        ALU_FunSel;
    logic [1:0]        ARF_OutCSel;
    logic [1:0]        ARF_OutDSel;
    logic [1:0]        ARF_FunSel;
    logic [2:0]        ARF_RegSel;
    logic              IR_LH;
    logic              IR_Enable;
    logic [1:0]        IR_Funsel;
    logic              Mem_WR;
    logic              Mem_CS;
    logic [1:0]        MuxASel;
    logic [1:0]        MuxBSel;
    logic              MuxCSel;

    logic [DATA_W-1:0] AOut;
    logic [DATA_W-1:0] BOut;
    logic [DATA_W-1:0] ALUOut;
    logic [DATA_W-1:0] ARF_COut;
    logic [DATA_W-1:0] Address;
    logic [DATA_W-1:0] MemoryOut;
    logic [DATA_W-1:0] MuxAOut;
    logic [DATA_W-1:0] MuxBOut;
    logic [DATA_W-1:0] MuxCOut;
    logic [3:0]        ALUOutFlag;
    logic [IR_W-1:0]   IROut;

    modport master (
        output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
               ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel,
        input  AOut, BOut, ALUOut, ARF_COut, Address, MemoryOut,
               MuxAOut, MuxBOut, MuxCOut, ALUOutFlag, IROut
    );

    modport slave (
        input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
               ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel,
        output AOut, BOut, ALUOut, ARF_COut, Address, MemoryOut,
               MuxAOut, MuxBOut, MuxCOut, ALUOutFlag, IROut
    );

endinterface

// File: rtl/alu_system_nbit_reg.sv
// Generic N-bit register with decrement / increment / load / clear.
// Holds when E is low; Reset clears it immediately.
module nbit_reg
    import alu_system_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         E,
    input  logic [1:0]   FunSel,
    input  logic [N-1:0] I,
    output logic [N-1:0] Q
);

    localparam logic [N-1:0] ONE = N'(1);

    // Apply the selected op on the rising edge while enabled
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Q <= '0;
        end else if (E) begin
            case (FunSel)
                FUN_DEC:  Q <= Q - ONE;
                FUN_INC:  Q <= Q + ONE;
                FUN_LOAD: Q <= I;
                FUN_CLR:  Q <= '0;
                default:  Q <= Q;
            endcase
        end
    end

endmodule

// File: rtl/alu_system.sv
// Datapath top: general register file R1-R4, address registers PC/AR/SP,
// 16-bit IR, 8-bit ALU with registered flags, 256x8 memory and source muxes.
// Every control input is a raw select; there is no sequencer here.
module alu_system
    import alu_system_pkg::*;
(
    input logic         Clock,
    input logic         Reset,
    alu_system_if.slave bus
);

    logic [DATA_W-1:0] rfQ  [4];
    logic [DATA_W-1:0] arfQ [3];
    logic [IR_W-1:0]   irQ;
    logic [IR_W-1:0]   irIn;

    logic [DATA_W-1:0] aOut;
    logic [DATA_W-1:0] bOut;
    logic [DATA_W-1:0] arfCOut;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] memOut;
    logic [DATA_W-1:0] muxAOut;
    logic [DATA_W-1:0] muxBOut;
    logic [DATA_W-1:0] muxCOut;

    logic [DATA_W-1:0] aluA;
    logic [DATA_W-1:0] aluB;
    logic [DATA_W-1:0] aluRes;
    logic [DATA_W:0]   addSum;
    logic [DATA_W:0]   subSum;
    logic              addOver;
    logic              subOver;
    logic              carryNext;
    logic              overNext;
    aluOp_t            aluOp;

    logic              flagZ;
    logic              flagC;
    logic              flagN;
    logic              flagO;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // General registers: RF_RegSel bit3 enables R1 down to bit0 for R4
    for (genvar g = 0; g < 4; g++) begin : gRf
        nbit_reg #(.N(DATA_W)) uReg (
            .Clock  (Clock),
            .Reset  (Reset),
            .E      (~bus.RF_RegSel[3-g]),
            .FunSel (bus.RF_FunSel),
            .I      (muxAOut),
            .Q      (rfQ[g])
        );
    end

    // Address registers: index 0 PC, 1 AR, 2 SP; ARF_RegSel bit2 is PC
    for (genvar g = 0; g < 3; g++) begin : gArf
        nbit_reg #(.N(DATA_W)) uReg (
            .Clock  (Clock),
            .Reset  (Reset),
            .E      (~bus.ARF_RegSel[2-g]),
            .FunSel (bus.ARF_FunSel),
            .I      (muxBOut),
            .Q      (arfQ[g])
        );
    end

    // IR load replaces only the chosen byte; inc/dec/clear span all 16 bits
    assign irIn = bus.IR_LH ? {memOut, irQ[DATA_W-1:0]}
                            : {irQ[IR_W-1:DATA_W], memOut};

    nbit_reg #(.N(IR_W)) uIr (
        .Clock  (Clock),
        .Reset  (Reset),
        .E      (bus.IR_Enable),
        .FunSel (bus.IR_Funsel),
        .I      (irIn),
        .Q      (irQ)
    );

    assign aOut    = rfQ[bus.RF_OutASel];
    assign bOut    = rfQ[bus.RF_OutBSel];
    assign arfCOut = arfPick(bus.ARF_OutCSel, arfQ[0], arfQ[1], arfQ[2]);
    assign address = arfPick(bus.ARF_OutDSel, arfQ[0], arfQ[1], arfQ[2]);

    // RF input source
    always_comb begin
        muxAOut = aluRes;
        case (bus.MuxASel)
            MUX_ALU:  muxAOut = aluRes;
            MUX_MEM:  muxAOut = memOut;
            MUX_IR:   muxAOut = irQ[DATA_W-1:0];
            MUX_ARFC: muxAOut = arfCOut;
            default:  muxAOut = aluRes;
        endcase
    end

    // ARF input source, same encoding as the RF mux
    always_comb begin
        muxBOut = aluRes;
        case (bus.MuxBSel)
            MUX_ALU:  muxBOut = aluRes;
            MUX_MEM:  muxBOut = memOut;
            MUX_IR:   muxBOut = irQ[DATA_W-1:0];
            MUX_ARFC: muxBOut = arfCOut;
            default:  muxBOut = aluRes;
        endcase
    end

    assign muxCOut = (bus.MuxCSel == MUXC_ARFC) ? arfCOut : aOut;

    assign aluA   = muxCOut;
    assign aluB   = bOut;
    assign aluOp  = aluOp_t'(bus.ALU_FunSel);

    // Subtraction is A + ~B + 1 so the carry-out reads as "no borrow"
    assign addSum  = {1'b0, aluA} + {1'b0, aluB};
    assign subSum  = {1'b0, aluA} + {1'b0, ~aluB} + {{DATA_W{1'b0}}, 1'b1};
    assign addOver = (aluA[MSB] == aluB[MSB]) && (addSum[MSB] != aluA[MSB]);
    assign subOver = (aluA[MSB] != aluB[MSB]) && (subSum[MSB] != aluA[MSB]);

    // ALU result plus the C/O values to latch; ops that leave C or O alone
    // feed the current flag straight back
    always_comb begin
        aluRes    = aluA;
        carryNext = flagC;
        overNext  = flagO;
        case (aluOp)
            ALU_PASS_A: aluRes = aluA;
            ALU_PASS_B: aluRes = aluB;
            ALU_NOT_A:  aluRes = ~aluA;
            ALU_NOT_B:  aluRes = ~aluB;
            ALU_ADD: begin
                aluRes    = addSum[DATA_W-1:0];
                carryNext = addSum[DATA_W];
                overNext  = addOver;
            end
            ALU_SUB, ALU_CMP: begin
                aluRes    = subSum[DATA_W-1:0];
                carryNext = subSum[DATA_W];
                overNext  = subOver;
            end
            ALU_AND:    aluRes = aluA & aluB;
            ALU_OR:     aluRes = aluA | aluB;
            ALU_NAND:   aluRes = ~(aluA & aluB);
            ALU_XOR:    aluRes = aluA ^ aluB;
            ALU_LSL: begin
                aluRes    = {aluA[MSB-1:0], 1'b0};
                carryNext = aluA[MSB];
            end
            ALU_LSR: begin
                aluRes    = {1'b0, aluA[MSB:1]};
                carryNext = aluA[0];
            end
            ALU_ASL: begin
                aluRes    = {aluA[MSB-1:0], 1'b0};
                carryNext = aluA[MSB];
                overNext  = aluA[MSB] ^ aluA[MSB-1];
            end
            ALU_ASR: begin
                aluRes    = {aluA[MSB], aluA[MSB:1]};
                carryNext = aluA[0];
            end
            ALU_CSR: begin
                aluRes    = {aluA[0], aluA[MSB:1]};
                carryNext = aluA[0];
            end
            default: aluRes = aluA;
        endcase
    end

    // Flags latch every edge with no enable
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            flagZ <= 1'b0;
            flagC <= 1'b0;
            flagN <= 1'b0;
            flagO <= 1'b0;
        end else begin
            flagZ <= (aluRes == '0);
            flagC <= carryNext;
            flagN <= aluRes[MSB];
            flagO <= overNext;
        end
    end

    // Memory write; contents are deliberately outside the reset domain
    always_ff @(posedge Clock) begin
        if (!bus.Mem_CS && bus.Mem_WR) begin
            mem[address] <= aluRes;
        end
    end

    assign memOut = (!bus.Mem_CS && !bus.Mem_WR) ? mem[address] : '0;

    assign bus.AOut       = aOut;
    assign bus.BOut       = bOut;
    assign bus.ALUOut     = aluRes;
    assign bus.ARF_COut   = arfCOut;
    assign bus.Address    = address;
    assign bus.MemoryOut  = memOut;
    assign bus.MuxAOut    = muxAOut;
    assign bus.MuxBOut    = muxBOut;
    assign bus.MuxCOut    = muxCOut;
    assign bus.ALUOutFlag = {flagZ, flagC, flagN, flagO};
    assign bus.IROut      = irQ;

endmodule

// File: tb/tb_alu_system.sv
// Bench for the alu_system datapath: table of ALU vectors with flag
// expectations queued at drive time, plus hand sequences for memory, IR,
// register-file ops, ARF hold and mid-run reset.
module tb_alu_system;
    import alu_system_pkg::*;

    logic Clock;
    logic Reset;
    int   checks = 0;
    int   passed = 0;

    alu_system_if bus();

    alu_system dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] flg;
    } vec_t;

    localparam int NVEC = 21;
    vec_t       vecs [NVEC];
    logic [3:0] flagQ [$];
    logic [7:0] memQ  [$];

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    endtask

    task automatic idle();
        bus.RF_OutASel  = 2'b00;
        bus.RF_OutBSel  = 2'b01;
        bus.RF_FunSel   = FUN_LOAD;
        bus.RF_RegSel   = 4'b1111;
        bus.ALU_FunSel  = 4'h0;
        bus.ARF_OutCSel = 2'b00;
        bus.ARF_OutDSel = 2'b10;
        bus.ARF_FunSel  = FUN_LOAD;
        bus.ARF_RegSel  = 3'b111;
        bus.IR_LH       = 1'b0;
        bus.IR_Enable   = 1'b0;
        bus.IR_Funsel   = FUN_LOAD;
        bus.Mem_WR      = 1'b0;
        bus.Mem_CS      = 1'b1;
        bus.MuxASel     = 2'b00;
        bus.MuxBSel     = 2'b00;
        bus.MuxCSel     = 1'b0;
    endtask

    // Clear the chosen ARF register(s) then step them to val by inc or dec
    task automatic setArf(input logic [2:0] regSel, input logic [7:0] val);
        bus.ARF_RegSel = regSel;
        bus.ARF_FunSel = FUN_CLR;
        tick();
        if (val < 8'd128) begin
            bus.ARF_FunSel = FUN_INC;
            for (int i = 0; i < int'(val); i++) tick();
        end else begin
            bus.ARF_FunSel = FUN_DEC;
            for (int i = 0; i < 256 - int'(val); i++) tick();
        end
        bus.ARF_RegSel = 3'b111;
    endtask

    // Route a value into Rn (idx 0 = R1) through PC and MuxA
    task automatic setReg(input int idx, input logic [7:0] val);
        setArf(3'b011, val);
        bus.ARF_OutCSel = 2'b00;
        bus.MuxASel     = 2'b11;
        bus.RF_FunSel   = FUN_LOAD;
        bus.RF_RegSel   = ~(4'b1000 >> idx);
        tick();
        bus.RF_RegSel   = 4'b1111;
    endtask

    initial begin
        // op, A, B, ALUOut, {Z,C,N,O}
        vecs[0]  = '{4'h4, 8'h7F, 8'h01, 8'h80, 4'b0011};
        vecs[1]  = '{4'h4, 8'hFF, 8'h01, 8'h00, 4'b1100};
        vecs[2]  = '{4'h5, 8'h10, 8'h20, 8'hF0, 4'b0010};
        vecs[3]  = '{4'h6, 8'h55, 8'h55, 8'h00, 4'b1100};
        vecs[4]  = '{4'h5, 8'h80, 8'h01, 8'h7F, 4'b0101};
        vecs[5]  = '{4'h0, 8'h3C, 8'h00, 8'h3C, 4'b0101};
        vecs[6]  = '{4'h1, 8'h00, 8'h00, 8'h00, 4'b1101};
        vecs[7]  = '{4'h2, 8'h0F, 8'h00, 8'hF0, 4'b0111};
        vecs[8]  = '{4'h3, 8'h00, 8'hFF, 8'h00, 4'b1101};
        vecs[9]  = '{4'h7, 8'hF0, 8'h3C, 8'h30, 4'b0101};
        vecs[10] = '{4'h8, 8'h0F, 8'h30, 8'h3F, 4'b0101};
        vecs[11] = '{4'h9, 8'hFF, 8'hFF, 8'h00, 4'b1101};
        vecs[12] = '{4'hA, 8'hAA, 8'h55, 8'hFF, 4'b0111};
        vecs[13] = '{4'hB, 8'h81, 8'h00, 8'h02, 4'b0101};
        vecs[14] = '{4'hC, 8'h02, 8'h00, 8'h01, 4'b0001};
        vecs[15] = '{4'hD, 8'h40, 8'h00, 8'h80, 4'b0011};
        vecs[16] = '{4'hD, 8'hC0, 8'h00, 8'h80, 4'b0110};
        vecs[17] = '{4'hE, 8'h81, 8'h00, 8'hC0, 4'b0110};
        vecs[18] = '{4'hF, 8'h01, 8'h00, 8'h80, 4'b0110};
        vecs[19] = '{4'hF, 8'h02, 8'h00, 8'h01, 4'b0000};
        vecs[20] = '{4'hE, 8'h00, 8'h00, 8'h00, 4'b1000};

        Reset = 1'b1;
        idle();
        tick();
        tick();
        chk("reset AOut", bus.AOut, 16'h0);
        chk("reset BOut", bus.BOut, 16'h0);
        chk("reset ARF_COut", bus.ARF_COut, 16'h0);
        chk("reset IROut", bus.IROut, 16'h0);
        chk("reset flags", bus.ALUOutFlag, 16'h0);
        Reset = 1'b0;
        tick();

        // PC cleared then incremented three times, copied into R1
        setReg(0, 8'd3);
        #1;
        chk("R1 from PC", bus.AOut, 16'h03);

        // ALU table: R1 -> A via MuxC, R2 -> B
        for (int i = 0; i < NVEC; i++) begin
            setReg(0, vecs[i].a);
            setReg(1, vecs[i].b);
            bus.RF_OutASel = 2'b00;
            bus.RF_OutBSel = 2'b01;
            bus.MuxCSel    = 1'b0;
            bus.ALU_FunSel = vecs[i].op;
            #1;
            chk($sformatf("alu%0d out", i), bus.ALUOut, vecs[i].res);
            flagQ.push_back(vecs[i].flg);
            tick();
            bus.ALU_FunSel = 4'h0;
            chk($sformatf("alu%0d flags", i), bus.ALUOutFlag, flagQ.pop_front());
        end

        // Memory write of ALUOut at AR, read back, second location
        setReg(0, 8'hAB);
        setArf(3'b101, 8'h10);
        bus.ARF_OutDSel = 2'b10;
        bus.ALU_FunSel  = 4'h0;
        bus.MuxCSel     = 1'b0;
        bus.RF_OutASel  = 2'b00;
        bus.Mem_CS      = 1'b0;
        bus.Mem_WR      = 1'b1;
        #1;
        chk("mem out during write", bus.MemoryOut, 16'h0);
        chk("address AR", bus.Address, 16'h10);
        memQ.push_back(8'hAB);
        tick();
        bus.Mem_WR = 1'b0;
        #1;
        chk("mem read 0x10", bus.MemoryOut, memQ.pop_front());

        bus.Mem_CS = 1'b1;
        setReg(0, 8'h3C);
        bus.ARF_RegSel = 3'b101;
        bus.ARF_FunSel = FUN_INC;
        tick();
        bus.ARF_RegSel = 3'b111;
        bus.Mem_CS = 1'b0;
        bus.Mem_WR = 1'b1;
        memQ.push_back(8'h3C);
        tick();
        bus.Mem_WR = 1'b0;
        #1;
        chk("mem read 0x11", bus.MemoryOut, memQ.pop_front());
        bus.ARF_RegSel = 3'b101;
        bus.ARF_FunSel = FUN_DEC;
        tick();
        bus.ARF_RegSel = 3'b111;
        chk("mem reread 0x10", bus.MemoryOut, 16'h00AB);

        // IR half loads from memory, then full-width decrement and hold
        bus.IR_Enable = 1'b1;
        bus.IR_LH     = 1'b1;
        bus.IR_Funsel = FUN_LOAD;
        tick();
        chk("IR high load", bus.IROut, 16'hAB00);
        bus.IR_LH = 1'b0;
        tick();
        chk("IR low load", bus.IROut, 16'hABAB);
        bus.IR_Funsel = FUN_DEC;
        tick();
        chk("IR dec", bus.IROut, 16'hABAA);
        bus.IR_Enable = 1'b0;
        bus.IR_Funsel = FUN_CLR;
        tick();
        chk("IR hold", bus.IROut, 16'hABAA);
        bus.MuxASel = 2'b10;
        #1;
        chk("MuxA IR low", bus.MuxAOut, 16'h00AA);
        bus.Mem_CS = 1'b1;
        #1;
        chk("mem deselected", bus.MemoryOut, 16'h0);

        // ARF disabled across every op: PC=3C, AR=10, SP=FE hold
        setArf(3'b110, 8'hFE);
        bus.ARF_RegSel = 3'b111;
        bus.MuxBSel    = 2'b00;
        for (int f = 0; f < 4; f++) begin
            bus.ARF_FunSel = 2'(f);
            tick();
        end
        bus.ARF_OutCSel = 2'b00;
        #1;
        chk("PC hold", bus.ARF_COut, 16'h3C);
        bus.ARF_OutCSel = 2'b01;
        #1;
        chk("PC hold alt", bus.ARF_COut, 16'h3C);
        bus.ARF_OutCSel = 2'b10;
        #1;
        chk("AR hold", bus.ARF_COut, 16'h10);
        bus.ARF_OutCSel = 2'b11;
        #1;
        chk("SP hold", bus.ARF_COut, 16'hFE);

        // R3 and R4 together: clear then decrement wraps to FF
        bus.RF_RegSel  = 4'b1100;
        bus.RF_FunSel  = FUN_CLR;
        tick();
        bus.RF_OutASel = 2'b10;
        bus.RF_OutBSel = 2'b11;
        bus.RF_FunSel  = FUN_DEC;
        #1;
        chk("R3 old before edge", bus.AOut, 16'h0);
        tick();
        bus.RF_RegSel = 4'b1111;
        chk("R3 dec wrap", bus.AOut, 16'hFF);
        chk("R4 dec wrap", bus.BOut, 16'hFF);
        bus.RF_OutASel = 2'b00;
        #1;
        chk("R1 untouched", bus.AOut, 16'h3C);

        // Mid-run reset clears state without waiting for an edge
        bus.RF_OutASel  = 2'b10;
        bus.ARF_OutCSel = 2'b10;
        bus.ALU_FunSel  = 4'h2;
        tick();
        bus.ALU_FunSel  = 4'h0;
        Reset = 1'b1;
        #1;
        chk("midrst AOut", bus.AOut, 16'h0);
        chk("midrst BOut", bus.BOut, 16'h0);
        chk("midrst ARF_COut", bus.ARF_COut, 16'h0);
        chk("midrst IROut", bus.IROut, 16'h0);
        chk("midrst flags", bus.ALUOutFlag, 16'h0);
        bus.RF_RegSel = 4'b0000;
        bus.RF_FunSel = FUN_INC;
        tick();
        chk("inc blocked in reset", bus.AOut, 16'h0);
        Reset = 1'b0;
        bus.RF_RegSel = 4'b1101;
        tick();
        bus.RF_RegSel = 4'b1111;
        chk("inc after reset", bus.AOut, 16'h01);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
